// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a registered-output RAM: issues consecutive reads,
// absorbs the one-cycle read latency and streams the bytes out via a 2-entry FIFO.
module ram_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W:0]     len, issued, accepted;
  logic [ADDR_W-1:0]   addr;
  logic                vld_p1, last_p1;
  logic [DATA_W-1:0]   fifo_data [2];
  logic [1:0]          fifo_last;
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_count;
  logic [2:0]          occupancy;
  logic                pop, issue, accept_start, done_r;

  assign m_valid     = (fifo_count != 2'd0);
  assign m_data      = fifo_data[rd_ptr];
  assign m_last      = fifo_last[rd_ptr];
  assign pop         = m_valid && m_ready;
  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = addr;

  // Buffered beats plus the read still in flight, minus the one leaving now,
  // must stay below the FIFO depth for another read to be safe.
  assign occupancy    = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue        = (state == READ) && (issued < len) && (occupancy < 3'd2);
  assign accept_start = (state == IDLE) && start && (burst_len != '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_start) state_nx = READ;
      READ:    if (issue && (issued == len - CNT_ONE)) state_nx = DRAIN;
      DRAIN:   if (pop && (accepted == len - CNT_ONE)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: FSM, read issue and counters
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      accepted <= '0;
      addr     <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      vld_p1  <= issue;
      last_p1 <= issue && (issued == len - CNT_ONE);
      done_r  <= (state == DRAIN) && (state_nx == IDLE);
      if (accept_start) begin
        len      <= burst_len;
        addr     <= start_addr;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) begin
          addr   <= addr + ADDR_ONE;
          issued <= issued + CNT_ONE;
        end
        if (pop) accepted <= accepted + CNT_ONE;
      end
    end
  end

  // Stage p1: RAM return captured into the output FIFO with its last tag
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      fifo_last    <= 2'b00;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
    end else begin
      if (vld_p1) begin
        fifo_data[wr_ptr] <= ram_data;
        fifo_last[wr_ptr] <= last_p1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({vld_p1, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side sequencer placed directly downstream of the 16x8 dual-port RAM, in the RAM's read clock domain. On a start command it issues a burst of consecutive reads (`rd_en`/`rd_addr`) to the RAM and absorbs the RAM's one-cycle registered read latency. It presents the returned bytes as a valid/ready stream with a last-beat marker. A 2-entry output buffer allows full-rate streaming under continuous ready and lossless stalling under backpressure.

## Interface
- `ADDR_W`, default 4: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: RAM data width.
- `rd_clk` in 1: single clock, same as the RAM read clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: burst request; sampled only in IDLE.
- `start_addr` in ADDR_W: first address of the burst.
- `burst_len` in ADDR_W+1: number of beats, 1..2^ADDR_W. A value of 0 is ignored.
- `busy` out 1: high from the cycle after start is accepted until the cycle after the last beat is accepted.
- `done` out 1: one-cycle pulse in the cycle after the last beat's handshake.
- `ram_rd_en` out 1: drives the RAM `rd_en`.
- `ram_rd_addr` out ADDR_W: drives the RAM `rd_addr`.
- `ram_data` in DATA_W: connected to the RAM `data_out`; valid in the cycle after `ram_rd_en`.
- `m_valid` out 1: stream data valid.
- `m_data` out DATA_W: stream data.
- `m_last` out 1: marks the final beat of the burst; qualified by `m_valid`.
- `m_ready` in 1: downstream accept.

## Operation
- **FSM states**
  - IDLE -> READ when `start && burst_len != 0`. The block latches `start_addr` and `burst_len` and clears its counters.
  - READ -> DRAIN in the cycle after the final read is issued.
  - DRAIN -> IDLE on the handshake (`m_valid && m_ready`) of the beat with `m_last` set. `done` pulses in the following cycle.
- **Start handling**
  - `start` outside IDLE is ignored; there is no queuing.
  - `start` with `burst_len == 0` is ignored; the block stays in IDLE with no pulse.
- **Read issue**
  - In READ, `ram_rd_en` = `(issued < len) && (fifo_count + inflight - pop < 2)`.
    - `inflight` is 1 if `ram_rd_en` was high in the previous cycle.
    - `pop` is the current-cycle handshake.
    - This condition guarantees the buffer never overflows.
  - `ram_rd_addr` starts at `start_addr` and increments by 1 after each issued read.
  - The address wraps modulo 2^ADDR_W (15 -> 0).
  - `ram_rd_addr` holds its value when no read is issued.
- **Capture and output**
  - `ram_data` is pushed into the 2-entry FIFO in the cycle after `ram_rd_en`. The FIFO tag-carries `last` (set for issue index `len-1`).
  - `m_valid` = FIFO not empty.
  - `m_data`/`m_last` = FIFO head. They are stable while `m_valid && !m_ready`.
- **Counter widths**
  - `issued` and `accepted` counters are ADDR_W+1 bits, which allows a full 16-beat burst.
- **Reset mid-burst**
  - The FSM returns to IDLE, the FIFO and counters clear, and there is no `done` pulse.
  - The in-flight RAM return is discarded.
- **Reset values**
  - `busy`, `done`, `ram_rd_en`, `m_valid` and `m_last` = 0.
  - `ram_rd_addr` and `m_data` = 0.

## Timing
- `start` sampled at edge k:
  - `busy` = 1 and first `ram_rd_en` = 1 in cycle k+1.
  - Data at RAM output in k+2; pushed at end of k+2; first `m_valid` in cycle k+3.
- With `m_ready` held high, one beat is accepted per cycle. An N-beat burst has `m_valid` high for cycles k+3..k+2+N.
- Last handshake in cycle t:
  - `done` = 1 and `busy` = 0 in cycle t+1.
  - A new `start` is accepted at edge t+1 at the earliest.
- Backpressure: when `m_ready` drops, at most 2 beats are buffered and issue stalls within the same cycle. The first handshake after `m_ready` rises is on the current head; no beat is lost or duplicated.
- Simultaneous push and pop with FIFO full is not reachable, because issue gating prevents it.

## Test plan
- RAM preloaded with mem[i] = 8'hA0+i. Start addr 2, len 4, `m_ready` = 1 -> `m_data` A2, A3, A4, A5 on consecutive cycles k+3..k+6. `m_last` only with A5. `done` at k+7.
- Start addr 14, len 4 -> addresses 14, 15, 0, 1. Data AE, AF, A0, A1.
- Len 16 from addr 0 with `m_ready` toggling 1010… -> all 16 bytes A0..AF in order with no duplicates. `ram_rd_en` never asserted while `fifo_count + inflight - pop >= 2`.
- `m_ready` = 0 for 10 cycles after the first beat, len 5 -> `m_valid` held and `m_data` stable at the first beat. Exactly 2 reads outstanding, then the remaining beats stream once ready rises.
- `burst_len` = 0 with start -> `busy` stays 0, no `ram_rd_en`, no `done`. A second `start` during busy -> ignored, and the burst completes unchanged.
- `rst` asserted mid-burst (after 2 beats) -> all outputs 0 asynchronously, no `done`. A new burst after reset starts cleanly with correct data.
